// File: rtl/router_load_monitor.sv
// router_load_monitor
//   Counts flits arriving on all router input ports over a fixed epoch and
//   publishes a saturated (optionally averaged) load estimate for the port
//   power-gating level logic. Until a valid measurement exists the load reads
//   as all ones, so every port stays in its permanent (ungated) mode.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | gating disabled; counters cleared; load forced to all ones
//   WARMUP | counting first epoch; no valid load yet
//   RUN    | counting; routerLoad holds the latest (averaged) estimate
//
// Ports
//   clk         clock
//   reset       synchronous active-high reset
//   pgGlobalEn  power-gating enable, low forces IDLE
//   flitValid   per-port flit arrival this cycle
//   routerLoad  registered load estimate
//   pgEnable    high once routerLoad holds a real measurement
//   loadUpdate  one-cycle pulse on every measured routerLoad update

`ifndef PG_ROUTER_LOAD_SIZE
`define PG_ROUTER_LOAD_SIZE 8
`endif

module router_load_monitor #(
    parameter int NUM_PORTS = 5,
    parameter int EPOCH_LEN = 1024,
    parameter int LOAD_W    = `PG_ROUTER_LOAD_SIZE,
    parameter int SHIFT     = 0,
    parameter int AVG_EN    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pgGlobalEn,
    input  logic [NUM_PORTS-1:0] flitValid,
    output logic [LOAD_W-1:0]    routerLoad,
    output logic                 pgEnable,
    output logic                 loadUpdate
);

    localparam int ACC_W = $clog2(EPOCH_LEN * NUM_PORTS + 1);
    localparam int CNT_W = $clog2(EPOCH_LEN);
    localparam int PC_W  = $clog2(NUM_PORTS + 1);
    localparam int SUM_W = ACC_W + 1;
    // Wide enough to hold both the shifted sample and the load ceiling.
    localparam int CMP_W = (SUM_W > LOAD_W + 1) ? SUM_W : LOAD_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EPOCH_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [CMP_W-1:0] LOAD_MAX = (CMP_W'(1) << LOAD_W) - CMP_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LOAD_W-1:0]  load_q, load_d;
    logic               pg_q, pg_d;
    logic               upd_q, upd_d;

    logic [PC_W-1:0]    pop;
    logic [SUM_W-1:0]   sample;
    logic [ACC_W-1:0]   acc_sat;
    logic [CMP_W-1:0]   shifted;
    logic [LOAD_W-1:0]  scaled;
    logic [LOAD_W:0]    avg_sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pop = pop + PC_W'(flitValid[i]);
        end
    end

    // The current cycle's flits are included in the sample, so the epoch-end
    // cycle is counted even though the accumulator clears on the next edge.
    always_comb begin
        sample  = SUM_W'(acc_q) + SUM_W'(pop);
        acc_sat = (sample > SUM_W'(ACC_MAX)) ? ACC_MAX : sample[ACC_W-1:0];
        shifted = CMP_W'(sample) >> SHIFT;
        scaled  = (shifted > LOAD_MAX) ? LOAD_W'(LOAD_MAX) : shifted[LOAD_W-1:0];
        avg_sum = {1'b0, load_q} + {1'b0, scaled};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        load_d  = load_q;
        pg_d    = pg_q;
        upd_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                acc_d  = '0;
                load_d = '1;
                pg_d   = 1'b0;
                if (pgGlobalEn) begin
                    state_d = WARMUP;
                end
            end
            default: begin
                // Disable wins over an epoch end landing on the same cycle.
                if (!pgGlobalEn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                    load_d  = '1;
                    pg_d    = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    acc_d = '0;
                    upd_d = 1'b1;
                    if (state_q == WARMUP) begin
                        state_d = RUN;
                        load_d  = scaled;
                        pg_d    = 1'b1;
                    end else if (AVG_EN != 0) begin
                        load_d = LOAD_W'(avg_sum >> 1);
                    end else begin
                        load_d = scaled;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = acc_sat;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            load_q  <= '1;
            pg_q    <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            load_q  <= load_d;
            pg_q    <= pg_d;
            upd_q   <= upd_d;
        end
    end

    assign routerLoad = load_q;
    assign pgEnable   = pg_q;
    assign loadUpdate = upd_q;

endmodule
